// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: shares the memory between CPU and DMA requesters,
// inserts WAIT_CYC wait states and returns read data with a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int WAIT_CYC   = 1,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  // state  | meaning
  // IDLE   | sample requests, arbitrate, latch the winning access
  // ACCESS | mem_en pulse, wait counter loaded
  // WAIT   | count down remaining wait states
  // DONE   | owner's ack pulse, read data already captured
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);
  localparam logic [3:0] LIM     = 4'(STARVE_LIM);

  state_t      state;
  logic        owner_dma;
  logic [2:0]  wcnt;
  logic [3:0]  starve_cnt;
  logic        grant_cpu;
  logic        grant_dma;
  logic        access_end;

  assign cpu_stall = cpu_req & ~cpu_ack;

  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == IDLE) begin
      if (cpu_req && dma_req) begin
        grant_dma = (starve_cnt == LIM);
        grant_cpu = (starve_cnt != LIM);
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
  end

  // With no wait states the access completes straight out of ACCESS.
  assign access_end = ((state == ACCESS) && (WAIT_CYC == 0)) ||
                      ((state == WAIT) && (wcnt == 3'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_dma  <= 1'b0;
      wcnt       <= 3'd0;
      starve_cnt <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_cpu || grant_dma) begin
            owner_dma <= grant_dma;
            mem_en    <= 1'b1;
            mem_we    <= grant_dma ? dma_we    : cpu_we;
            mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
            mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            if (grant_dma)
              starve_cnt <= 4'd0;
            else if (dma_req && (starve_cnt != LIM))
              starve_cnt <= starve_cnt + 4'd1;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          wcnt <= WAIT_LD;
          if (WAIT_CYC > 0) state <= WAIT;
        end
        WAIT: begin
          if (wcnt != 3'd0) wcnt <= wcnt - 3'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (access_end) begin
        state <= DONE;
        if (owner_dma) begin
          dma_ack <= 1'b1;
          if (!mem_we) dma_rdata <= mem_rdata;
        end else begin
          cpu_ack <= 1'b1;
          if (!mem_we) cpu_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
